// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_chain
// Purpose  : Control-word pipeline ID->EX->MEM->WB with load-use bubbles,
//            branch flush, global freeze and a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_chain #(
    parameter int CTRL_W   = 22,
    parameter int NSTAGES  = 3,
    parameter int REG_W    = 5,
    parameter int LOAD_BIT = 10,
    parameter int RFEN_BIT = 9,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic                      id_valid,
    input  logic [REG_W-1:0]          id_dest,
    input  logic [REG_W-1:0]          id_rs,
    input  logic [REG_W-1:0]          id_rt,
    input  logic                      id_uses_rt,
    input  logic                      flush,
    input  logic                      ext_stall,
    output logic [NSTAGES*CTRL_W-1:0] stage_ctrl,
    output logic [NSTAGES-1:0]        stage_valid,
    output logic [NSTAGES*REG_W-1:0]  stage_dest,
    output logic                      hazard_stall,
    output logic [CNT_W-1:0]          bubble_count
);

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [REG_W-1:0] c_reg_zero = {REG_W{1'b0}};

    logic [CTRL_W-1:0] r_ctrl  [NSTAGES];
    logic [REG_W-1:0]  r_dest  [NSTAGES];
    logic [NSTAGES-1:0] r_valid;
    logic [CNT_W-1:0]  r_bcnt;

    logic              w_hazard_raw;
    logic              w_hazard_stall;
    logic              w_bubble;
    logic              w_count_evt;
    logic              w_src_match;
    logic [CTRL_W-1:0] w_s0_ctrl;
    logic [REG_W-1:0]  w_s0_dest;
    logic              w_s0_valid;

    // Load-use: EX holds a register-writing load whose result ID wants now.
    always_comb begin
        w_src_match  = (r_dest[0] == id_rs) ||
                       (id_uses_rt && (r_dest[0] == id_rt));
        w_hazard_raw = id_valid && r_valid[0] &&
                       r_ctrl[0][LOAD_BIT] && r_ctrl[0][RFEN_BIT] &&
                       (r_dest[0] != c_reg_zero) && w_src_match;
    end

    assign w_hazard_stall = w_hazard_raw && !flush;
    assign w_count_evt    = flush || w_hazard_stall;
    assign w_bubble       = w_count_evt || !id_valid;

    always_comb begin
        w_s0_ctrl  = '0;
        w_s0_dest  = '0;
        w_s0_valid = 1'b0;
        if (!w_bubble) begin
            w_s0_ctrl  = id_ctrl;
            w_s0_dest  = id_dest;
            w_s0_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NSTAGES; k++) begin
                r_ctrl[k] <= '0;
                r_dest[k] <= '0;
            end
            r_valid <= '0;
            r_bcnt  <= '0;
        end else if (!ext_stall) begin
            for (int k = NSTAGES - 1; k > 0; k--) begin
                r_ctrl[k]  <= r_ctrl[k-1];
                r_dest[k]  <= r_dest[k-1];
                r_valid[k] <= r_valid[k-1];
            end
            r_ctrl[0]  <= w_s0_ctrl;
            r_dest[0]  <= w_s0_dest;
            r_valid[0] <= w_s0_valid;
            if (w_count_evt && (r_bcnt != c_cnt_max)) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NSTAGES; g++) begin : g_pack
            assign stage_ctrl[g*CTRL_W +: CTRL_W] = r_ctrl[g];
            assign stage_dest[g*REG_W +: REG_W]   = r_dest[g];
        end
    endgenerate

    assign stage_valid  = r_valid;
    assign hazard_stall = w_hazard_stall;
    assign bubble_count = r_bcnt;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised chain of control-signal pipeline registers that carries decoded control words from ID through EX, MEM and WB. It replaces fixed per-stage control registers and the single-select bubble mux. It adds a valid bit per stage, load-use hazard detection with automatic bubble insertion, branch flush, global freeze and a saturating bubble counter. It sits between the control unit / IF-ID register and the datapath stage registers.

Parameters:
CTRL_W, 22, width of one control word
NSTAGES, 3, number of stages after ID (stage 0 = EX, 1 = MEM, 2 = WB); legal range >= 2
REG_W, 5, register-specifier width
LOAD_BIT, 10, index of Load_Instr bit within the control word
RFEN_BIT, 9, index of RF_Enable bit within the control word
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
id_ctrl  in  CTRL_W  control word from the control unit for the instruction in ID
id_valid  in  1  ID holds a real instruction
id_dest  in  REG_W  destination register of the ID instruction
id_rs  in  REG_W  rs of the ID instruction
id_rt  in  REG_W  rt of the ID instruction
id_uses_rt  in  1  ID instruction reads rt as a source
flush  in  1  taken branch/jump; kill the ID instruction
ext_stall  in  1  freeze the whole chain
stage_ctrl  out  NSTAGES*CTRL_W  registered control words; stage k occupies bits [k*CTRL_W +: CTRL_W]
stage_valid  out  NSTAGES  registered valid bit per stage
stage_dest  out  NSTAGES*REG_W  registered destination per stage; same packing as stage_ctrl
hazard_stall  out  1  combinational; holds PC, nPC and IF-ID this cycle
bubble_count  out  CNT_W  bubbles inserted by flush or hazard

Behaviour:
- Reset (reset==0 at a clk edge): stage_ctrl, stage_valid, stage_dest and bubble_count all become 0. Reset overrides ext_stall.
- hazard_raw: asserted when all of the following hold:
  - id_valid
  - stage_valid[0]
  - stage_ctrl[0][LOAD_BIT] and stage_ctrl[0][RFEN_BIT]
  - stage_dest[0] != 0
  - stage_dest[0]==id_rs, or (id_uses_rt and stage_dest[0]==id_rt)
- hazard_stall = hazard_raw & ~flush. It is purely combinational and is reported even while ext_stall is high.
- Bubble: stage 0 loads ctrl=0, valid=0, dest=0.
- Per rising edge, with reset==1, priority is:
  1. ext_stall=1: all stage registers and bubble_count hold.
  2. Otherwise, stage k+1 <= stage k for k = 0..NSTAGES-2; the last stage's contents are discarded.
  3. Stage 0 loads a bubble if flush, hazard_stall or ~id_valid. Otherwise it loads {id_ctrl, 1, id_dest}.
- Latency: an ID instruction accepted at edge n appears at stage k after edge n+k. Only registered outputs depend on the edge; hazard_stall has no latency.
- A load-use hazard produces exactly one bubble. After the edge the load is in stage 1, so hazard_raw drops unless the new stage 0 contents cause a new hazard.
- Flush and hazard in the same cycle: one bubble is inserted, hazard_stall=0, and the counter increments once.
- bubble_count increments by 1 on each non-frozen edge where flush | hazard_stall is asserted. It saturates at all-ones with no wrap. Bubbles caused only by ~id_valid are not counted.
- A synchronous reset mid-stall or mid-flush clears everything on that edge. The first cycle after reset shows all stages invalid and hazard_stall=0.

Test Plan:
1. Reset: hold reset=0 for 2 edges with random inputs -> all outputs 0; release and drive id_valid=1, id_ctrl=22'h0_0200, id_dest=3 -> after 1/2/3 edges stage_valid = 001/011/111, stage_dest[2]=3.
2. Load-use: load (bits 10,9 set, dest=5) in stage 0; ID id_rs=5 -> hazard_stall=1; next edge stage 0 is a bubble, stage 1 holds the load, bubble_count=1, hazard_stall=0. Repeat with id_uses_rt=1, id_rt=5 -> same result; with id_uses_rt=0 -> no stall.
3. Register zero and non-load: load with dest=0 and id_rs=0 -> no stall; ALU instruction (bit 10 clear) with dest=5 and id_rs=5 -> no stall.
4. Flush with a simultaneous hazard: flush=1 with hazard_raw true -> hazard_stall=0, one bubble inserted, bubble_count +1 (not +2).
5. ext_stall: assert for 3 edges mid-stream -> stage registers and bubble_count unchanged; on deassert, the chain resumes with no lost or duplicated words.
6. Saturation: CNT_W=2, force 5 flushes -> bubble_count is 1,2,3,3,3; then reset -> 0.
